func_sweep: RTL and testbench

Self-checking stimulus sequencer that sits directly upstream of the 16-function logic unit `func`. It drives `func`'s `sel`/`a`/`b` inputs through all 64 combinations and samples `z` back. Each sample is checked against the defined function encoding, z = sel[{a,b}]. The block reports pass/fail, an error count and the first failing vector, replacing hand-written vector lists with a hardware sweep usable in simulation and on silicon.

---
 rtl/func_sweep_if.sv | 31 +++
 rtl/func_sweep.sv | 115 +++++++++++
 tb/tb_func_sweep.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/func_sweep_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | func_sweep_if : sequencer <-> func / host signal bundle   rev 1.0   |
// +--------------------------------------------------------------------+
interface func_sweep_if;
  logic       start;
  logic [3:0] sel_o;
  logic       a_o;
  logic       b_o;
  logic       z_i;
  logic       busy;
  logic       done;
  logic       pass;
  logic [6:0] err_cnt;
  logic       fail_valid;
  logic [3:0] fail_sel;
  logic [1:0] fail_ab;

  modport slave (
    input  start, z_i,
    output sel_o, a_o, b_o, busy, done, pass, err_cnt,
           fail_valid, fail_sel, fail_ab
  );

  modport master (
    output start, z_i,
    input  sel_o, a_o, b_o, busy, done, pass, err_cnt,
           fail_valid, fail_sel, fail_ab
  );
endinterface
`default_nettype wire

// File: rtl/func_sweep.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | func_sweep : 64-vector self-checking sweep of the func unit  rev 1.0|
// +--------------------------------------------------------------------+
module func_sweep #(
  parameter int SETTLE = 1
) (
  input  wire logic     clk,
  input  wire logic     rst,
  func_sweep_if.slave   bus
);

  localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_idx;
  logic [3:0] r_settle;
  logic [6:0] r_err;
  logic       r_pass;
  logic       r_fail_valid;
  logic [3:0] r_fail_sel;
  logic [1:0] r_fail_ab;

  logic [3:0] w_vec_sel;
  logic       w_exp;
  logic       w_mis;
  logic       w_active;

  // The select nibble doubles as the truth table, indexed by {a,b}.
  assign w_vec_sel = r_idx[5:2];
  assign w_exp     = w_vec_sel[r_idx[1:0]];
  assign w_mis     = (bus.z_i != w_exp);
  assign w_active  = (r_state == S_DRIVE) || (r_state == S_SAMPLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_state_nxt = S_DRIVE;
      S_DRIVE:  if (r_settle == c_SETTLE_LAST) w_state_nxt = S_SAMPLE;
      S_SAMPLE: w_state_nxt = (r_idx == 6'd63) ? S_DONE : S_DRIVE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx        <= 6'd0;
      r_settle     <= 4'd0;
      r_err        <= 7'd0;
      r_pass       <= 1'b0;
      r_fail_valid <= 1'b0;
      r_fail_sel   <= 4'd0;
      r_fail_ab    <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_settle <= 4'd0;
          if (bus.start) begin
            r_idx        <= 6'd0;
            r_err        <= 7'd0;
            r_pass       <= 1'b0;
            r_fail_valid <= 1'b0;
            r_fail_sel   <= 4'd0;
            r_fail_ab    <= 2'd0;
          end
        end
        S_DRIVE: begin
          if (r_settle == c_SETTLE_LAST) r_settle <= 4'd0;
          else                           r_settle <= r_settle + 4'd1;
        end
        S_SAMPLE: begin
          if (w_mis) begin
            r_err <= r_err + 7'd1;
            if (!r_fail_valid) begin
              r_fail_valid <= 1'b1;
              r_fail_sel   <= r_idx[5:2];
              r_fail_ab    <= r_idx[1:0];
            end
          end
          // Pass folds in the final sample so it is valid in the done cycle.
          if (r_idx == 6'd63) r_pass <= (r_err == 7'd0) && !w_mis;
          else                r_idx  <= r_idx + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = w_active;
  assign bus.done       = (r_state == S_DONE);
  assign bus.sel_o      = w_active ? r_idx[5:2] : 4'd0;
  assign bus.a_o        = w_active ? r_idx[1]   : 1'b0;
  assign bus.b_o        = w_active ? r_idx[0]   : 1'b0;
  assign bus.pass       = r_pass;
  assign bus.err_cnt    = r_err;
  assign bus.fail_valid = r_fail_valid;
  assign bus.fail_sel   = r_fail_sel;
  assign bus.fail_ab    = r_fail_ab;

endmodule
`default_nettype wire

// File: tb/tb_func_sweep.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_func_sweep : directed bench for func_sweep (SETTLE 1 and 3) rev 1.0|
// +--------------------------------------------------------------------+
module tb_func_sweep;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  int   which = 0;   // 0: SETTLE=1 instance, 1: SETTLE=3 instance
  int   mode  = 0;   // 0 good, 1 stuck0, 2 stuck1, 3 inverted, 4 delayed by 2
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  func_sweep_if if1 ();
  func_sweep_if if3 ();

  func_sweep #(.SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  func_sweep #(.SETTLE(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  function automatic logic f_func(input logic [3:0] s, input logic a, input logic b);
    return s[{a, b}];
  endfunction

  logic w_f1, w_f3;
  logic r_d1a = 1'b0, r_d1b = 1'b0, r_d3a = 1'b0, r_d3b = 1'b0;
  assign w_f1 = f_func(if1.sel_o, if1.a_o, if1.b_o);
  assign w_f3 = f_func(if3.sel_o, if3.a_o, if3.b_o);

  always @(posedge clk) begin
    r_d1a <= w_f1; r_d1b <= r_d1a;
    r_d3a <= w_f3; r_d3b <= r_d3a;
  end

  function automatic logic f_model(input int m, input logic f, input logic fd);
    case (m)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return ~f;
      4:       return fd;
      default: return f;
    endcase
  endfunction

  assign if1.z_i   = f_model(mode, w_f1, r_d1b);
  assign if3.z_i   = f_model(mode, w_f3, r_d3b);
  assign if1.start = start && (which == 0);
  assign if3.start = start && (which == 1);

  logic       w_busy, w_done, w_pass, w_fv;
  logic [6:0] w_err;
  logic [3:0] w_fsel;
  logic [1:0] w_fab;
  assign w_busy = which ? if3.busy       : if1.busy;
  assign w_done = which ? if3.done       : if1.done;
  assign w_pass = which ? if3.pass       : if1.pass;
  assign w_fv   = which ? if3.fail_valid : if1.fail_valid;
  assign w_err  = which ? if3.err_cnt    : if1.err_cnt;
  assign w_fsel = which ? if3.fail_sel   : if1.fail_sel;
  assign w_fab  = which ? if3.fail_ab    : if1.fail_ab;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulses start, then watches until 4 cycles past the first done.
  task automatic run_sweep(input int restart_at, input bit restart_done,
                           output int done_cyc, output int n_done);
    int cyc;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 1;
    done_cyc = 0;
    n_done = 0;
    chk("busy_cycle1", w_busy, 1);
    while (cyc < 600) begin
      start = (cyc == restart_at) || (w_done && restart_done);
      if (w_done) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc = cyc;
          chk("busy_in_done", w_busy, 0);
        end
      end
      if (done_cyc != 0 && cyc >= done_cyc + 4) break;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (done_cyc == 0) chk("sweep_timeout", 0, 1);
  endtask

  int dc, nd, cnt;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", if1.busy, 0);
    chk("rst_done", if1.done, 0);
    chk("rst_err", if1.err_cnt, 0);
    chk("rst_pass", if1.pass, 0);
    chk("rst_fv", if1.fail_valid, 0);
    chk("rst_drive", {if1.sel_o, if1.a_o, if1.b_o}, 0);
    rst = 1'b0;

    mode = 0; which = 0;
    run_sweep(-1, 0, dc, nd);
    chk("good_done_cyc", dc, 129);
    chk("good_n_done", nd, 1);
    chk("good_pass", w_pass, 1);
    chk("good_err", w_err, 0);
    chk("good_fv", w_fv, 0);

    mode = 1;
    run_sweep(-1, 0, dc, nd);
    chk("st0_err", w_err, 32);
    chk("st0_pass", w_pass, 0);
    chk("st0_fv", w_fv, 1);
    chk("st0_fsel", w_fsel, 1);
    chk("st0_fab", w_fab, 0);

    mode = 2;
    run_sweep(-1, 0, dc, nd);
    chk("st1_err", w_err, 32);
    chk("st1_fsel", w_fsel, 0);
    chk("st1_fab", w_fab, 0);

    mode = 3;
    run_sweep(-1, 0, dc, nd);
    chk("inv_err", w_err, 64);
    chk("inv_pass", w_pass, 0);

    mode = 4; which = 1;
    run_sweep(-1, 0, dc, nd);
    chk("dly3_done_cyc", dc, 257);
    chk("dly3_pass", w_pass, 1);
    chk("dly3_err", w_err, 0);

    which = 0;
    run_sweep(-1, 0, dc, nd);
    chk("dly1_pass", w_pass, 0);
    chk("dly1_fsel", w_fsel, 1);
    chk("dly1_fab", w_fab, 0);

    mode = 1;
    run_sweep(40, 1, dc, nd);
    chk("rep_n_done", nd, 1);
    chk("rep_done_cyc", dc, 129);
    chk("rep_idle", w_busy, 0);
    chk("rep_err_hold", w_err, 32);
    chk("rep_fv_hold", w_fv, 1);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("new_busy", w_busy, 1);
    chk("new_err_clr", w_err, 0);
    chk("new_fv_clr", w_fv, 0);
    cnt = 0;
    while (!w_done && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    chk("new_done_seen", w_done, 1);
    repeat (2) @(negedge clk);

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (49) @(negedge clk);
    chk("pre_rst_err_nz", (w_err != 0), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", if1.busy, 0);
    chk("mid_rst_drive", {if1.sel_o, if1.a_o, if1.b_o}, 0);
    chk("mid_rst_err", if1.err_cnt, 0);
    chk("mid_rst_fail", {if1.fail_valid, if1.fail_sel, if1.fail_ab}, 0);
    chk("mid_rst_pass_done", {if1.pass, if1.done}, 0);
    @(negedge clk) rst = 1'b0;
    nd = 0;
    repeat (150) begin
      @(negedge clk);
      if (w_done) nd++;
    end
    chk("post_rst_no_done", nd, 0);
    mode = 0;
    run_sweep(-1, 0, dc, nd);
    chk("fresh_done_cyc", dc, 129);
    chk("fresh_pass", w_pass, 1);
    chk("fresh_err", w_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
